// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-ported register file.
// Holds default sizes, address-width derivation and the zero word.
package regfile_mp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_NUM    = 32;

    localparam logic [DEF_DATA_WIDTH-1:0] ZERO_WORD = '0;

    // Address width for n registers; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Youngest-write-port select for one queried register address.
// Used per register for commit and per read port for bypass.
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_NUM    = DEF_REG_NUM,
    parameter int WR_PORTS   = 2,
    parameter int ADDR_W     = addr_w(REG_NUM)
) (
    input  logic [WR_PORTS-1:0]            we,
    input  logic [WR_PORTS*ADDR_W-1:0]     waddr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]              qaddr,
    output logic                           hit,
    output logic [DATA_WIDTH-1:0]          data
);

    logic q_ok;

    assign q_ok = (qaddr != '0) && (int'(qaddr) < REG_NUM);

    // Scan oldest to youngest so a younger matching port overrides.
    always_comb begin
        hit  = 1'b0;
        data = DATA_WIDTH'(ZERO_WORD);
        for (int p = 0; p < WR_PORTS; p++) begin
            if (q_ok && we[p] && (waddr[p*ADDR_W +: ADDR_W] == qaddr)) begin
                hit  = 1'b1;
                data = wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with busy scoreboard and read bypass.
// Register 0 is hardwired to zero and never marked busy.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_NUM    = DEF_REG_NUM,
    parameter int WR_PORTS   = 2,
    parameter int RD_PORTS   = 4,
    parameter int REG_READ   = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [WR_PORTS-1:0]                      we,
    input  logic [WR_PORTS*addr_w(REG_NUM)-1:0]      waddr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]           wdata,
    input  logic [RD_PORTS-1:0]                      re,
    input  logic [RD_PORTS*addr_w(REG_NUM)-1:0]      raddr,
    output logic [RD_PORTS*DATA_WIDTH-1:0]           rdata,
    input  logic [WR_PORTS-1:0]                      sb_set,
    input  logic [WR_PORTS*addr_w(REG_NUM)-1:0]      sb_addr,
    input  logic                                     flush,
    output logic [RD_PORTS-1:0]                      rbusy
);

    localparam int ADDR_W = addr_w(REG_NUM);

    logic [DATA_WIDTH-1:0] regs    [REG_NUM];
    logic [REG_NUM-1:0]    busy;
    logic [REG_NUM-1:0]    wr_hit;
    logic [DATA_WIDTH-1:0] wr_val  [REG_NUM];
    logic [REG_NUM-1:0]    sb_hit;
    logic [RD_PORTS-1:0]   byp_hit;
    logic [DATA_WIDTH-1:0] byp_val [RD_PORTS];
    logic [DATA_WIDTH-1:0] rd_next [RD_PORTS];

    // One arbiter per register decides which port's data commits there.
    for (genvar r = 0; r < REG_NUM; r++) begin : g_commit
        regfile_wr_arb #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_NUM    (REG_NUM),
            .WR_PORTS   (WR_PORTS),
            .ADDR_W     (ADDR_W)
        ) u_arb (
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (ADDR_W'(r)),
            .hit   (wr_hit[r]),
            .data  (wr_val[r])
        );
    end

    // One arbiter per read port finds the youngest same-cycle write.
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_bypass
        regfile_wr_arb #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_NUM    (REG_NUM),
            .WR_PORTS   (WR_PORTS),
            .ADDR_W     (ADDR_W)
        ) u_arb (
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (raddr[i*ADDR_W +: ADDR_W]),
            .hit   (byp_hit[i]),
            .data  (byp_val[i])
        );
    end

    // Decode mark-busy strobes into a per-register set vector.
    always_comb begin
        sb_hit = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (sb_set[p] && (sb_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    sb_hit[r] = 1'b1;
                end
            end
        end
    end

    // Commit writes and update busy bits; new producer beats completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
            if (flush) begin
                busy <= '0;
            end else begin
                busy <= (busy & ~wr_hit) | sb_hit;
            end
        end
    end

    // Per-port read value and busy flag, both bypassing same-cycle writes.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              ra_ok;
        rbusy = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            ra         = raddr[i*ADDR_W +: ADDR_W];
            ra_ok      = (ra != '0) && (int'(ra) < REG_NUM);
            rd_next[i] = '0;
            if (re[i] && !rst && ra_ok) begin
                rd_next[i] = byp_hit[i] ? byp_val[i] : regs[ra];
                rbusy[i]   = busy[ra] && !byp_hit[i];
            end
        end
    end

    if (REG_READ == 0) begin : g_comb_rd
        // Combinational read straight from the bypass mux.
        always_comb begin
            rdata = '0;
            for (int i = 0; i < RD_PORTS; i++) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_next[i];
            end
        end
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] rd_q [RD_PORTS];

        // Capture the bypassed read value for next-cycle delivery.
        always_ff @(posedge clk) begin
            for (int i = 0; i < RD_PORTS; i++) begin
                rd_q[i] <= rst ? '0 : rd_next[i];
            end
        end

        // Drive registered data, held at zero while reset is asserted.
        always_comb begin
            rdata = '0;
            for (int i = 0; i < RD_PORTS; i++) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = rst ? '0 : rd_q[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, random traffic, reset burst.
// Both read modes run side by side from the same stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int WP = 2;
    localparam int RP = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [WP-1:0]   we;
    logic [WP*AW-1:0] waddr;
    logic [WP*DW-1:0] wdata;
    logic [RP-1:0]   re;
    logic [RP*AW-1:0] raddr;
    logic [RP*DW-1:0] rdata_c, rdata_r;
    logic [WP-1:0]   sb_set;
    logic [WP*AW-1:0] sb_addr;
    logic            flush;
    logic [RP-1:0]   rbusy_c, rbusy_r;

    regfile_mp #(.DATA_WIDTH(DW), .REG_NUM(RN), .WR_PORTS(WP),
                 .RD_PORTS(RP), .REG_READ(0)) dut_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_c), .sb_set(sb_set),
        .sb_addr(sb_addr), .flush(flush), .rbusy(rbusy_c)
    );

    regfile_mp #(.DATA_WIDTH(DW), .REG_NUM(RN), .WR_PORTS(WP),
                 .RD_PORTS(RP), .REG_READ(1)) dut_r (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_r), .sb_set(sb_set),
        .sb_addr(sb_addr), .flush(flush), .rbusy(rbusy_r)
    );

    // Reference state: architectural registers, busy flags, pending reads.
    logic [DW-1:0] m_reg  [RN];
    bit            m_busy [RN];
    logic [DW-1:0] m_prev [RP];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          rst;
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic [19:0] raddr;
        logic [1:0]  sb_set;
        logic [9:0]  sb_addr;
        bit          flush;
        logic [31:0] e_d;
        bit          e_b;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; we = '0; waddr = '0; wdata = '0; re = '0;
        raddr = '0; sb_set = '0; sb_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        re[i] = 1'b1;
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_sb(input int p, input int a);
        sb_set[p] = 1'b1;
        sb_addr[p*AW +: AW] = AW'(a);
    endtask

    // Expected read: zero when disabled/reset/r0, else youngest writer or stored value.
    function automatic logic [31:0] exp_rd(input int i);
        int a = int'(raddr[i*AW +: AW]);
        if (rst || !re[i] || a == 0 || a >= RN) return '0;
        for (int p = WP - 1; p >= 0; p--) begin
            if (we[p] && int'(waddr[p*AW +: AW]) == a) return wdata[p*DW +: DW];
        end
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input int i);
        int a = int'(raddr[i*AW +: AW]);
        if (rst || !re[i] || a == 0 || a >= RN) return 1'b0;
        for (int p = 0; p < WP; p++) begin
            if (we[p] && int'(waddr[p*AW +: AW]) == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    // Apply the currently driven inputs for one clock and check every port.
    task automatic cycle(input bit has_exp, input logic [31:0] e_d, input bit e_b);
        logic [31:0] ec [RP];
        #3;
        for (int i = 0; i < RP; i++) begin
            ec[i] = exp_rd(i);
            chk($sformatf("rdata_comb[%0d]", i), rdata_c[i*DW +: DW], ec[i]);
            chk($sformatf("rdata_reg[%0d]", i), rdata_r[i*DW +: DW],
                rst ? 32'h0 : m_prev[i]);
            chk($sformatf("rbusy_comb[%0d]", i), {31'b0, rbusy_c[i]}, {31'b0, exp_busy(i)});
            chk($sformatf("rbusy_reg[%0d]", i), {31'b0, rbusy_r[i]}, {31'b0, exp_busy(i)});
        end
        if (has_exp) begin
            chk("tbl_rdata0", rdata_c[31:0], e_d);
            chk("tbl_rbusy0", {31'b0, rbusy_c[0]}, {31'b0, e_b});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < RN; r++) begin
                m_reg[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < WP; p++) begin
                int a = int'(waddr[p*AW +: AW]);
                if (we[p] && a != 0) begin
                    m_reg[a] = wdata[p*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            for (int p = 0; p < WP; p++) begin
                int a = int'(sb_addr[p*AW +: AW]);
                if (sb_set[p] && a != 0) m_busy[a] = 1'b1;
            end
            if (flush) begin
                for (int r = 0; r < RN; r++) m_busy[r] = 1'b0;
            end
        end
        for (int i = 0; i < RP; i++) m_prev[i] = ec[i];
    endtask

    function automatic vec_t mk(input bit r, input logic [1:0] w,
                                input int wa1, input int wa0,
                                input logic [31:0] wd1, input logic [31:0] wd0,
                                input int ra0, input logic [1:0] s,
                                input int sa1, input int sa0, input bit f,
                                input logic [31:0] ed, input bit eb);
        vec_t v;
        v.rst = r;
        v.we = w;
        v.waddr = {AW'(wa1), AW'(wa0)};
        v.wdata = {wd1, wd0};
        v.raddr = {5'd9, 5'd4, 5'd3, AW'(ra0)};
        v.sb_set = s;
        v.sb_addr = {AW'(sa1), AW'(sa0)};
        v.flush = f;
        v.e_d = ed;
        v.e_b = eb;
        return v;
    endfunction

    initial begin
        for (int r = 0; r < RN; r++) begin
            m_reg[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int i = 0; i < RP; i++) m_prev[i] = '0;

        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 5, 2'b00, 0, 0, 0, 32'h0, 0);
        tbl[1]  = mk(0, 2'b11, 5, 5, 32'hBBBB, 32'hAAAA, 5, 2'b00, 0, 0, 0, 32'hBBBB, 0);
        tbl[2]  = mk(0, 2'b00, 0, 0, 0, 0, 5, 2'b00, 0, 0, 0, 32'hBBBB, 0);
        tbl[3]  = mk(0, 2'b01, 0, 7, 0, 32'h1234, 7, 2'b00, 0, 0, 0, 32'h1234, 0);
        tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 7, 2'b00, 0, 0, 0, 32'h1234, 0);
        tbl[5]  = mk(0, 2'b00, 0, 0, 0, 0, 3, 2'b01, 0, 3, 0, 32'h0, 0);
        tbl[6]  = mk(0, 2'b00, 0, 0, 0, 0, 3, 2'b00, 0, 0, 0, 32'h0, 1);
        tbl[7]  = mk(0, 2'b10, 3, 0, 32'h33, 0, 3, 2'b00, 0, 0, 0, 32'h33, 0);
        tbl[8]  = mk(0, 2'b00, 0, 0, 0, 0, 3, 2'b00, 0, 0, 0, 32'h33, 0);
        tbl[9]  = mk(0, 2'b10, 4, 0, 32'h44, 0, 4, 2'b01, 0, 4, 0, 32'h44, 0);
        tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 4, 2'b00, 0, 0, 0, 32'h44, 1);
        tbl[11] = mk(0, 2'b00, 0, 0, 0, 0, 4, 2'b01, 0, 9, 1, 32'h44, 1);
        tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 4, 2'b00, 0, 0, 0, 32'h44, 0);
        tbl[13] = mk(0, 2'b01, 0, 0, 0, 32'hFFFF, 0, 2'b10, 0, 0, 0, 32'h0, 0);
        tbl[14] = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0);
        tbl[15] = mk(0, 2'b00, 0, 0, 0, 0, 9, 2'b00, 0, 0, 0, 32'h0, 0);

        // Directed table.
        for (int k = 0; k < 16; k++) begin
            clr_in();
            rst = tbl[k].rst;
            we = tbl[k].we;
            waddr = tbl[k].waddr;
            wdata = tbl[k].wdata;
            re = 4'b1111;
            raddr = tbl[k].raddr;
            sb_set = tbl[k].sb_set;
            sb_addr = tbl[k].sb_addr;
            flush = tbl[k].flush;
            cycle(1, tbl[k].e_d, tbl[k].e_b);
        end

        // Registered-read latency: write and read r7 together, data appears next cycle.
        clr_in();
        set_wr(0, 7, 32'h5678);
        set_rd(0, 7);
        cycle(1, 32'h5678, 0);
        clr_in();
        #2;
        chk("reg_read_latency", rdata_r[31:0], 32'h5678);
        cycle(1, 32'h0, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            clr_in();
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < WP; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                          : $urandom_range(0, 7), $urandom);
                if ($urandom_range(0, 2) == 0)
                    set_sb(p, $urandom_range(0, 7));
            end
            for (int i = 0; i < RP; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                          : $urandom_range(0, 7));
            end
            cycle(0, 32'h0, 0);
        end

        // Fill r1..r31 with busy marks, then reset in the middle of the burst.
        for (int k = 1; k < RN; k += 2) begin
            clr_in();
            set_wr(0, k, 32'h1000 + k);
            set_sb(0, k);
            if (k + 1 < RN) begin
                set_wr(1, k + 1, 32'h1000 + k + 1);
                set_sb(1, k + 1);
            end
            set_rd(0, k);
            set_rd(1, (k > 2) ? k - 2 : 1);
            cycle(0, 32'h0, 0);
        end
        clr_in();
        set_rd(0, 5);
        #2;
        chk("pre_rst_r5", rdata_c[31:0], 32'h1005);
        chk("pre_rst_busy5", {31'b0, rbusy_c[0]}, 32'h1);
        cycle(0, 32'h0, 0);
        clr_in();
        rst = 1'b1;
        set_wr(0, 5, 32'hDEADBEEF);
        set_wr(1, 6, 32'hCAFEF00D);
        set_sb(0, 7);
        set_rd(0, 5);
        set_rd(1, 6);
        cycle(1, 32'h0, 0);
        for (int k = 0; k < 8; k++) begin
            clr_in();
            for (int i = 0; i < RP; i++) set_rd(i, k * RP + i);
            #2;
            for (int i = 0; i < RP; i++) begin
                chk($sformatf("post_rst_data_r%0d", k * RP + i), rdata_c[i*DW +: DW], 32'h0);
                chk($sformatf("post_rst_busy_r%0d", k * RP + i), {31'b0, rbusy_c[i]}, 32'h0);
            end
            cycle(0, 32'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
